vga_timing_gen: RTL and testbench

//  Source end of the pixel-coordinate interface consumed by every *_mapper sprite block.

---
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bundle driven by vga_timing_gen and consumed by the
// sprite mappers and the compositor.
interface vga_timing_gen_if #(
  parameter int FRAME_W = 8
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank;
  logic               hs;
  logic               vs;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: two wrapping counters (column/row) advanced by
// pix_ce, with registered visible/sync decodes, a frame_start pulse and a
// frame counter.
// Optional build macro SYNC_DELAY_EN: delays hs/vs by two vga_clk cycles so
// sync edges line up with mapper RGB (ROM read + output register).
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FRAME_W   = 8
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               pix_ce,
  vga_timing_gen_if.master   vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Half-open range test used for both sync decodes.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [9:0]         x_p0, y_p0;
  logic               blank_p0, hs_p0, vs_p0, fs_p0;
  logic [FRAME_W-1:0] fcnt_p0;

  logic [9:0] x_nxt, y_nxt;
  logic       x_wrap, frame_wrap;

  // Next counter position; only terminal-value compares, no overflow path.
  always_comb begin
    x_wrap     = (x_p0 == H_LAST);
    frame_wrap = x_wrap && (y_p0 == V_LAST);
    x_nxt      = x_wrap ? 10'd0 : x_p0 + 10'd1;
    y_nxt      = y_p0;
    if (x_wrap) y_nxt = (y_p0 == V_LAST) ? 10'd0 : y_p0 + 10'd1;
  end

  // Stage p0: counters plus decodes of the next position, registered together.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_p0     <= H_LAST;
      y_p0     <= V_LAST;
      blank_p0 <= 1'b0;
      hs_p0    <= 1'b1;
      vs_p0    <= 1'b1;
      fs_p0    <= 1'b0;
      fcnt_p0  <= '0;
    end else begin
      fs_p0 <= 1'b0;
      if (pix_ce) begin
        x_p0     <= x_nxt;
        y_p0     <= y_nxt;
        blank_p0 <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_p0    <= !in_range(x_nxt, HS_START, HS_END);
        vs_p0    <= !in_range(y_nxt, VS_START, VS_END);
        if (frame_wrap) begin
          fs_p0   <= 1'b1;
          fcnt_p0 <= fcnt_p0 + 1'b1;
        end
      end
    end
  end

`ifdef SYNC_DELAY_EN
  logic hs_p1, hs_p2, vs_p1, vs_p2;

  // Stages p1/p2: free-running sync delay, independent of pix_ce.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs_p1 <= 1'b1;
      hs_p2 <= 1'b1;
      vs_p1 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      hs_p1 <= hs_p0;
      hs_p2 <= hs_p1;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign vif.hs = hs_p2;
  assign vif.vs = vs_p2;
`else
  assign vif.hs = hs_p0;
  assign vif.vs = vs_p0;
`endif

  assign vif.DrawX       = x_p0;
  assign vif.DrawY       = y_p0;
  assign vif.blank       = blank_p0;
  assign vif.frame_start = fs_p0;
  assign vif.frame_cnt   = fcnt_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so that
// hundreds of frames fit in a short run. The reference tracks a linear pixel
// index within the frame and derives column/row and region flags from it.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VV = 6, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HV + HF + HSY + HB;   // 15
  localparam int VT = VV + VF + VSY + VB;   // 10
  localparam int FW = 8;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce  = 1'b1;

  vga_timing_gen_if #(.FRAME_W(FW)) vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .FRAME_W(FW)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .pix_ce (pix_ce),
    .vif    (vif)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: position index within the frame, pulse and frame count.
  int m_pos;
  int m_cnt;
  bit m_fs;
  bit m_d1_hs, m_d2_hs, m_d1_vs, m_d2_vs;
  int dut_fs_seen;
  int hs_low_cycles;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mx(); return m_pos % HT; endfunction
  function automatic int my(); return m_pos / HT; endfunction
  function automatic bit m_blank(); return (mx() < HV) && (my() < VV); endfunction
  function automatic bit m_hs();
    return !((mx() >= HV + HF) && (mx() < HV + HF + HSY));
  endfunction
  function automatic bit m_vs();
    return !((my() >= VV + VF) && (my() < VV + VF + VSY));
  endfunction

  // Apply inputs, take one clock, advance the reference, then compare.
  task automatic step(input bit rn, input bit ce);
    bit hs_old, vs_old;
    reset_n = rn;
    pix_ce  = ce;
    hs_old  = m_hs();
    vs_old  = m_vs();
    @(posedge vga_clk);
    if (!rn) begin
      m_pos = HT * VT - 1;
      m_cnt = 0;
      m_fs  = 1'b0;
      m_d1_hs = 1'b1; m_d2_hs = 1'b1; m_d1_vs = 1'b1; m_d2_vs = 1'b1;
    end else begin
      m_d2_hs = m_d1_hs; m_d1_hs = hs_old;
      m_d2_vs = m_d1_vs; m_d1_vs = vs_old;
      m_fs = 1'b0;
      if (ce) begin
        m_pos = (m_pos + 1) % (HT * VT);
        if (m_pos == 0) begin
          m_fs  = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << FW);
        end
      end
    end
    #1;
    check("DrawX", 32'(vif.DrawX), 32'(mx()));
    check("DrawY", 32'(vif.DrawY), 32'(my()));
    check("blank", 32'(vif.blank), 32'(m_blank()));
`ifdef SYNC_DELAY_EN
    check("hs", 32'(vif.hs), 32'(m_d2_hs));
    check("vs", 32'(vif.vs), 32'(m_d2_vs));
`else
    check("hs", 32'(vif.hs), 32'(m_hs()));
    check("vs", 32'(vif.vs), 32'(m_vs()));
`endif
    check("frame_start", 32'(vif.frame_start), 32'(m_fs));
    check("frame_cnt", 32'(vif.frame_cnt), 32'(m_cnt));
    if (vif.frame_start) dut_fs_seen++;
    if (!vif.hs) hs_low_cycles++;
  endtask

  initial begin
    m_pos = HT * VT - 1;
    m_cnt = 0;
    m_fs  = 1'b0;
    m_d1_hs = 1'b1; m_d2_hs = 1'b1; m_d1_vs = 1'b1; m_d2_vs = 1'b1;
    dut_fs_seen   = 0;
    hs_low_cycles = 0;

    // Reset held with pix_ce high: reset values must win.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("rst_DrawX", 32'(vif.DrawX), 32'(HT - 1));
    check("rst_DrawY", 32'(vif.DrawY), 32'(VT - 1));

    // First release edge enters (0,0).
    step(1'b1, 1'b1);
    check("first_fs", 32'(vif.frame_start), 32'd1);
    check("first_cnt", 32'(vif.frame_cnt), 32'd1);
    check("first_blank", 32'(vif.blank), 32'd1);

    // Free run through 256+ frames: frame counter wraps.
    dut_fs_seen   = 0;
    hs_low_cycles = 0;
    for (int i = 0; i < 257 * HT * VT; i++) step(1'b1, 1'b1);
    check("fs_pulses", 32'(dut_fs_seen), 32'd257);
    check("hs_low_total", 32'(hs_low_cycles), 32'(257 * HSY * VT));

    // pix_ce toggling: everything at half rate, pulse still one clock wide.
    dut_fs_seen = 0;
    for (int i = 0; i < 2 * 2 * HT * VT; i++) step(1'b1, (i % 2) == 0);
    check("fs_pulses_half", 32'(dut_fs_seen), 32'd2);

    // Mid-frame single-cycle reset at a chosen position (bounded search).
    begin
      int guard = 0;
      while (!(m_pos == 3 * HT + 5) && guard < 2 * HT * VT) begin
        step(1'b1, 1'b1);
        guard++;
      end
      check("reach_pos", 32'(guard < 2 * HT * VT), 32'd1);
    end
    step(1'b0, 1'b1);
    check("midrst_DrawX", 32'(vif.DrawX), 32'(HT - 1));
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_fs", 32'(vif.frame_start), 32'd1);
    check("midrst_cnt", 32'(vif.frame_cnt), 32'd1);

    // Random pix_ce with occasional reset pulses.
    for (int i = 0; i < 6000; i++)
      step(($urandom_range(0, 199) != 0), $urandom_range(0, 2) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
